// File: rtl/meta_data_fifo.sv
// First-word-fall-through FIFO for one metadata AXI-Stream branch.
// Buffers words between the metadata doubler and a slow consumer; reports occupancy and almost-full.

module meta_data_fifo #(
  parameter int unsigned DW           = 512,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned AFULL_THRESH = 12
) (
  input  logic                       clk,
  input  logic                       resetn,

  input  logic [DW-1:0]              AXIS_IN_MD_TDATA,
  input  logic                       AXIS_IN_MD_TVALID,
  output logic                       AXIS_IN_MD_TREADY,

  output logic [DW-1:0]              AXIS_OUT_MD_TDATA,
  output logic                       AXIS_OUT_MD_TVALID,
  input  logic                       AXIS_OUT_MD_TREADY,

  output logic [$clog2(DEPTH):0]     md_count,
  output logic                       md_afull,
  output logic                       md_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [AW:0] PtrOne   = (AW+1)'(1);
  localparam logic [AW:0] AfullThr = (AW+1)'(AFULL_THRESH);

  logic [DW-1:0] mem_q [DEPTH];

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;

  logic full;
  logic empty;
  logic wr_en;
  logic rd_en;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign wr_en = AXIS_IN_MD_TVALID && !full;
  assign rd_en = AXIS_OUT_MD_TREADY && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is deliberately not reset; empty masking hides stale contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= AXIS_IN_MD_TDATA;
    end
  end

  // Ready is gated by reset so upstream sees no acceptance while the FIFO is held clear.
  assign AXIS_IN_MD_TREADY  = resetn && !full;
  assign AXIS_OUT_MD_TVALID = !empty;
  assign AXIS_OUT_MD_TDATA  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  assign md_count = wr_ptr_q - rd_ptr_q;
  assign md_afull = (md_count >= AfullThr);
  assign md_empty = empty;

endmodule

// File: tb/tb_meta_data_fifo.sv
// Directed bench for meta_data_fifo: stimulus pushes expected words into a queue,
// a monitor pops and compares on every read handshake.

module tb_meta_data_fifo;

  localparam int DW    = 512;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic           clk = 1'b0;
  logic           resetn;
  logic [DW-1:0]  in_tdata;
  logic           in_tvalid;
  logic           in_tready;
  logic [DW-1:0]  out_tdata;
  logic           out_tvalid;
  logic           out_tready;
  logic [AW:0]    md_count;
  logic           md_afull;
  logic           md_empty;

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q [$];

  always #5 clk = ~clk;

  meta_data_fifo #(
    .DW           (DW),
    .DEPTH        (DEPTH),
    .AFULL_THRESH (12)
  ) dut (
    .clk                (clk),
    .resetn             (resetn),
    .AXIS_IN_MD_TDATA   (in_tdata),
    .AXIS_IN_MD_TVALID  (in_tvalid),
    .AXIS_IN_MD_TREADY  (in_tready),
    .AXIS_OUT_MD_TDATA  (out_tdata),
    .AXIS_OUT_MD_TVALID (out_tvalid),
    .AXIS_OUT_MD_TREADY (out_tready),
    .md_count           (md_count),
    .md_afull           (md_afull),
    .md_empty           (md_empty)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input logic [31:0] v, input bit expect_accept);
    in_tvalid = 1'b1;
    in_tdata  = DW'(v);
    if (expect_accept) exp_q.push_back(DW'(v));
  endtask

  task automatic drain(input int budget);
    bit done = 1'b0;
    out_tready = 1'b1;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge clk);
      if (md_empty) done = 1'b1;
      else cyc();
    end
    chk("drain_done", 64'(done), 64'(1));
    cyc();
    out_tready = 1'b0;
  endtask

  // Monitor: inputs change at posedge+1, so a handshake seen at negedge completes next edge.
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (resetn && out_tvalid && out_tready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL rd_unexpected: got %0h, want no word", out_tdata[63:0]);
        end else begin
          e = exp_q.pop_front();
          if (out_tdata !== e) begin
            n_err++;
            $display("FAIL rd_data: got %0h, want %0h (t=%0t)", out_tdata, e, $time);
          end
        end
      end
    end
  end

  initial begin
    resetn     = 1'b0;
    in_tvalid  = 1'b0;
    in_tdata   = '0;
    out_tready = 1'b0;

    // Reset then idle
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_tready", 64'(in_tready), 64'(0));
    chk("rst_tvalid", 64'(out_tvalid), 64'(0));
    chk("rst_tdata",  out_tdata[63:0], 64'(0));
    chk("rst_count",  64'(md_count), 64'(0));
    chk("rst_empty",  64'(md_empty), 64'(1));
    chk("rst_afull",  64'(md_afull), 64'(0));
    cyc();
    resetn = 1'b1;
    cyc();
    @(negedge clk);
    chk("idle_tready", 64'(in_tready), 64'(1));
    chk("idle_tvalid", 64'(out_tvalid), 64'(0));
    cyc();

    // Single word latency
    drive_word(32'hA5, 1'b1);
    cyc();
    in_tvalid = 1'b0;
    @(negedge clk);
    chk("lat_tvalid", 64'(out_tvalid), 64'(1));
    chk("lat_tdata",  out_tdata[63:0], 64'hA5);
    chk("lat_count",  64'(md_count), 64'(1));
    cyc();
    drain(8);
    @(negedge clk);
    chk("lat_empty_tdata", out_tdata[63:0], 64'(0));
    cyc();

    // Fill to full
    for (int i = 1; i <= 16; i++) begin
      drive_word(32'(i), 1'b1);
      @(negedge clk);
      chk("fill_count", 64'(md_count), 64'(i - 1));
      chk("fill_afull", 64'(md_count), 64'(i - 1));
      chk("fill_afull_flag", 64'(md_afull), 64'((i - 1) >= 12));
      cyc();
    end
    drive_word(32'd17, 1'b0);
    @(negedge clk);
    chk("full_count",  64'(md_count), 64'(16));
    chk("full_afull",  64'(md_afull), 64'(1));
    chk("full_tready", 64'(in_tready), 64'(0));
    cyc();
    in_tvalid = 1'b0;
    @(negedge clk);
    chk("no_17th", 64'(md_count), 64'(16));
    cyc();

    // Full plus simultaneous read: no write slips in
    drive_word(32'd99, 1'b0);
    out_tready = 1'b1;
    @(negedge clk);
    chk("fr_tready", 64'(in_tready), 64'(0));
    cyc();
    in_tvalid  = 1'b0;
    out_tready = 1'b0;
    @(negedge clk);
    chk("fr_count",  64'(md_count), 64'(15));
    chk("fr_tready_after", 64'(in_tready), 64'(1));
    cyc();
    drain(40);
    chk("fill_q_left", 64'(exp_q.size()), 64'(0));

    // Wrap-around with concurrent write and read
    for (int i = 0; i < 3; i++) begin
      drive_word(32'h100 + 32'(i), 1'b1);
      cyc();
    end
    out_tready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      drive_word(32'h103 + 32'(k), 1'b1);
      @(negedge clk);
      chk("wrap_count", 64'(md_count), 64'(3));
      cyc();
    end
    in_tvalid  = 1'b0;
    out_tready = 1'b0;
    drain(10);
    chk("wrap_q_left", 64'(exp_q.size()), 64'(0));

    // Reset mid-stream at count 7
    for (int i = 0; i < 7; i++) begin
      drive_word(32'h200 + 32'(i), 1'b1);
      cyc();
    end
    in_tvalid = 1'b0;
    @(negedge clk);
    chk("pre_rst_count", 64'(md_count), 64'(7));
    cyc();
    resetn = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_tvalid", 64'(out_tvalid), 64'(0));
    chk("mid_rst_count",  64'(md_count), 64'(0));
    chk("mid_rst_empty",  64'(md_empty), 64'(1));
    chk("mid_rst_tdata",  out_tdata[63:0], 64'(0));
    cyc();
    resetn = 1'b1;
    drive_word(32'h3C3C, 1'b1);
    cyc();
    in_tvalid = 1'b0;
    @(negedge clk);
    chk("post_rst_count", 64'(md_count), 64'(1));
    chk("post_rst_tdata", out_tdata[63:0], 64'h3C3C);
    cyc();
    drain(8);
    chk("post_rst_q_left", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/meta_data_fifo.md
# meta_data_fifo

Synchronous first-word-fall-through FIFO for one metadata AXI-Stream branch. It sits directly downstream of the metadata doubler, one instance per output branch. It absorbs rate differences between the two consumers so that a slow consumer does not stall the shared input through the doubler's combined TREADY. It also reports occupancy and an almost-full flag for upstream throttling.

## Interface

Parameters:
- DW, 512, data width of TDATA in bits.
- DEPTH, 16, number of entries; must be a power of two, minimum 2.
- AFULL_THRESH, 12, occupancy at or above which `md_afull` asserts; range 1..DEPTH.
- AW (localparam), log2(DEPTH), pointer index width.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- resetn, input, 1, asynchronous active-low reset.
- AXIS_IN_MD_TDATA, input, DW, write-side data.
- AXIS_IN_MD_TVALID, input, 1, write-side valid.
- AXIS_IN_MD_TREADY, output, 1, write-side ready; high when the FIFO is not full.
- AXIS_OUT_MD_TDATA, output, DW, head-of-FIFO data; all zeros when empty.
- AXIS_OUT_MD_TVALID, output, 1, high when the FIFO is not empty.
- AXIS_OUT_MD_TREADY, input, 1, read-side ready.
- md_count, output, AW+1, current occupancy, 0..DEPTH.
- md_afull, output, 1, high when md_count >= AFULL_THRESH.
- md_empty, output, 1, high when md_count == 0.

## Operation

- Storage: DEPTH x DW register array. The array is not reset.
- Pointers: wr_ptr and rd_ptr are each AW+1 bits. The low AW bits index the array. The MSB is the wrap bit.
- Both pointers increment by 1 and wrap modulo 2^(AW+1). There is no other arithmetic on them.
- Full: wr_ptr[AW] != rd_ptr[AW] and wr_ptr[AW-1:0] == rd_ptr[AW-1:0].
- Empty: wr_ptr == rd_ptr.
- md_count = wr_ptr - rd_ptr, computed modulo 2^(AW+1).
- Write: when AXIS_IN_MD_TVALID && AXIS_IN_MD_TREADY, store TDATA at wr_ptr and increment wr_ptr.
- Read: when AXIS_OUT_MD_TVALID && AXIS_OUT_MD_TREADY, increment rd_ptr.
- AXIS_IN_MD_TREADY = !full. TREADY stays low when full even if a read happens in the same cycle; there is no pass-through on full.
- AXIS_OUT_MD_TVALID = !empty.
- AXIS_OUT_MD_TDATA = empty ? 0 : mem[rd_ptr[AW-1:0]].
- Simultaneous write and read, not full and not empty: both pointers advance and md_count is unchanged.
- Simultaneous write and read when empty: the read does not occur because TVALID is low. Only the write takes effect.
- When full, only a read can take effect.
- The FIFO never drops data and never overwrites an unread entry.
- Once TVALID is high, TDATA at the head stays stable until the read handshake completes. This meets the AXI-Stream rule that valid and data hold until accepted.

## Timing

- Reset (resetn low), asynchronous:
  - wr_ptr and rd_ptr go to 0.
  - AXIS_IN_MD_TREADY = 0 while resetn is low, and 1 from the first cycle after release.
  - AXIS_OUT_MD_TVALID = 0, AXIS_OUT_MD_TDATA = 0.
  - md_count = 0, md_afull = 0, md_empty = 1.
- Reset asserted mid-operation: all queued entries are discarded immediately. After release the FIFO behaves as empty, and stale array contents are never presented.
- Write-to-read latency: a word accepted at rising edge N appears on AXIS_OUT_MD_TDATA with TVALID high after edge N, i.e. in cycle N+1.
- Throughput: one write and one read per cycle sustained.
- Flag timing:
  - md_count, md_afull and md_empty reflect the pointer values after each edge.
  - TREADY deasserts in the cycle after the write that fills the FIFO.
  - TREADY reasserts in the cycle after the first read from full.
- All outputs are combinational from registered pointers and the array. There is no combinational path from either TVALID or TREADY input to any output.

## Test plan

- Reset then idle: hold resetn low 3 cycles, then release. Required: TREADY low during reset, then 1; TVALID = 0; TDATA = 0; md_count = 0; md_empty = 1.
- Single word latency: write 0xA5 (zero-extended to DW) at edge N with out TREADY = 0. Required: TVALID = 1 and TDATA = 0xA5 in cycle N+1; md_count = 1.
- Fill to full with DEPTH = 16, out TREADY = 0: write values 1..16.
  - md_afull rises when md_count reaches 12.
  - TREADY = 0 after the 16th write.
  - A 17th TVALID-high cycle is not accepted.
  - Draining then yields 1..16 in order.
- Wrap-around and concurrency: hold both TVALID and TREADY high for 40 cycles with an incrementing pattern. Required: md_count constant, output sequence equal to input sequence delayed, pointers wrap with no loss.
- Full plus simultaneous read: at md_count = 16, assert out TREADY for one cycle while in TVALID is high. Required: no write that cycle; md_count = 15; TREADY = 1 in the next cycle.
- Reset mid-stream: at md_count = 7, pulse resetn low for 1 cycle. Required: TVALID = 0 and md_count = 0 immediately; the next write is read back correctly.
